// File: rtl/pipeline_processor_8b.sv
// 8-bit 3-stage (IF/EX/WB) pipelined processor with WB->EX forwarding, branch squash and HALT/resume.
// Optional PIPELINE_TRACE_EN adds simulation-only writeback/store trace output.

module pp8_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr_a,
    input  logic [2:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b
);
    logic [7:0] registers [0:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) registers[i] <= 8'h00;
        end else if (we) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata_a = registers[raddr_a];
    assign rdata_b = registers[raddr_b];
endmodule

module pp8_datamem (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] memory [0:15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) memory[i] <= 8'h00;
        end else if (we) begin
            memory[addr] <= wdata;
        end
    end

    // Read is combinational so LD sees a store made by the previous instruction.
    assign rdata = memory[addr];
endmodule

module pipeline_processor_8b #(
    parameter string PROG_FILE  = "program.hex",
    parameter int    IMEM_DEPTH = 256
) (
    input  logic       main_clk,
    input  logic       restart,
    input  logic       controller_enable,
    input  logic       resume,
    output logic       halted,
    output logic [7:0] pc
);
    localparam logic [15:0] NOP = 16'h0000;

    logic [15:0] rom [0:IMEM_DEPTH-1];

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = NOP;
    end

    logic [15:0] ex_instr;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;

    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm;
    assign op  = ex_instr[15:12];
    assign rd  = ex_instr[11:9];
    assign rs1 = ex_instr[8:6];
    assign rs2 = ex_instr[5:3];
    assign imm = ex_instr[7:0];

    logic [7:0] rf_a, rf_b, opa, opb, mem_rdata;
    logic       rf_we, mem_we, mem_we_q;

    pp8_regfile r1 (
        .clk     (main_clk),
        .rst_n   (restart),
        .we      (rf_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // WB->EX bypass removes every data hazard in a 3-stage pipe.
    assign opa = (wb_we && (wb_rd == rs1)) ? wb_data : rf_a;
    assign opb = (wb_we && (wb_rd == rs2)) ? wb_data : rf_b;

    pp8_datamem m1 (
        .clk   (main_clk),
        .rst_n (restart),
        .we    (mem_we_q),
        .addr  (opa[3:0]),
        .wdata (opb),
        .rdata (mem_rdata)
    );

    assign rf_we    = controller_enable & wb_we;
    assign mem_we_q = controller_enable & mem_we;

    logic       ex_we, branch, halt_hit;
    logic [7:0] ex_result;

    always_comb begin
        ex_we     = 1'b0;
        ex_result = 8'h00;
        mem_we    = 1'b0;
        branch    = 1'b0;
        halt_hit  = 1'b0;
        case (op)
            4'h1: begin ex_we = 1'b1; ex_result = opa + opb; end
            4'h2: begin ex_we = 1'b1; ex_result = opa - opb; end
            4'h3: begin ex_we = 1'b1; ex_result = opa & opb; end
            4'h4: begin ex_we = 1'b1; ex_result = opa | opb; end
            4'h5: begin ex_we = 1'b1; ex_result = opa ^ opb; end
            4'h6: begin ex_we = 1'b1; ex_result = imm; end
            4'h7: begin ex_we = 1'b1; ex_result = mem_rdata; end
            4'h8: mem_we   = 1'b1;
            4'h9: branch   = (opa == 8'h00);
            4'hA: branch   = 1'b1;
            4'hB: halt_hit = 1'b1;
            default: ;
        endcase
    end

    // Freeze (enable=0) beats halt; halt squashes fetch and keeps pc at the address after HALT.
    always_ff @(posedge main_clk or negedge restart) begin
        if (!restart) begin
            pc       <= 8'h00;
            halted   <= 1'b0;
            ex_instr <= NOP;
            wb_we    <= 1'b0;
            wb_rd    <= 3'd0;
            wb_data  <= 8'h00;
        end else if (controller_enable) begin
            wb_we   <= ex_we;
            wb_rd   <= rd;
            wb_data <= ex_result;
            if (halted) begin
                ex_instr <= NOP;
                if (resume) halted <= 1'b0;
            end else if (halt_hit) begin
                halted   <= 1'b1;
                ex_instr <= NOP;
            end else if (branch) begin
                pc       <= imm;
                ex_instr <= NOP;
            end else begin
                ex_instr <= rom[pc];
                pc       <= pc + 8'd1;
            end
        end
    end

`ifdef PIPELINE_TRACE_EN
    always @(posedge main_clk) begin
        if (restart && controller_enable) begin
            if (wb_we)  $display("WB r%0d = %b", wb_rd, wb_data);
            if (mem_we) $display("ST m[%0d] = %b", opa[3:0], opb);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_processor_8b.sv
// Directed bench for pipeline_processor_8b: table-checked programs plus halt/resume, freeze and async-reset sequences.
module tb_pipeline_processor_8b;
  logic       main_clk;
  logic       restart;
  logic       controller_enable;
  logic       resume;
  logic       halted;
  logic [7:0] pc;

  int total = 0;
  int bad   = 0;

  pipeline_processor_8b #(.PROG_FILE(""), .IMEM_DEPTH(256)) dut (
    .main_clk          (main_clk),
    .restart           (restart),
    .controller_enable (controller_enable),
    .resume            (resume),
    .halted            (halted),
    .pc                (pc)
  );

  // clock
  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // kind: 0 register, 1 memory, 2 pc, 3 halted
  typedef struct {
    int         prog;
    int         kind;
    int         idx;
    logic [7:0] exp;
  } chk_t;
  chk_t tbl[$];

  function automatic logic [15:0] e_ldi(input logic [2:0] rd, input logic [7:0] v);
    return {4'h6, rd, 1'b0, v};
  endfunction
  function automatic logic [15:0] e_alu(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] a, input logic [2:0] b);
    return {op, rd, a, b, 3'b000};
  endfunction
  function automatic logic [15:0] e_ld(input logic [2:0] rd, input logic [2:0] a);
    return {4'h7, rd, a, 6'b000000};
  endfunction
  function automatic logic [15:0] e_st(input logic [2:0] a, input logic [2:0] b);
    return {4'h8, 3'b000, a, b, 3'b000};
  endfunction
  // target = {a[1:0], t6} because rs1 and imm8 share bits 7:6
  function automatic logic [15:0] e_beqz(input logic [2:0] a, input logic [5:0] t6);
    return {4'h9, 3'b000, a, t6};
  endfunction
  function automatic logic [15:0] e_jmp(input logic [7:0] t);
    return {4'hA, 4'h0, t};
  endfunction
  localparam logic [15:0] HALT = 16'hB000;
  localparam logic [15:0] NOPI = 16'h0000;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge main_clk);
  endtask

  task automatic load_prog(input int id);
    for (int i = 0; i < 256; i++) dut.rom[i] = NOPI;
    case (id)
      0: begin
        dut.rom[0] = e_ldi(3'd1, 8'd5);
        dut.rom[1] = e_ldi(3'd2, 8'd3);
        dut.rom[2] = e_alu(4'h1, 3'd3, 3'd1, 3'd2);
        dut.rom[3] = e_alu(4'h2, 3'd4, 3'd1, 3'd2);
        dut.rom[4] = e_alu(4'h3, 3'd5, 3'd1, 3'd2);
        dut.rom[5] = e_alu(4'h4, 3'd6, 3'd1, 3'd2);
        dut.rom[6] = e_alu(4'h5, 3'd7, 3'd1, 3'd2);
        dut.rom[7] = HALT;
      end
      1: begin
        dut.rom[0] = e_ldi(3'd1, 8'h04);
        dut.rom[1] = e_ldi(3'd2, 8'hAA);
        dut.rom[2] = e_st(3'd1, 3'd2);
        dut.rom[3] = e_ld(3'd5, 3'd1);
        dut.rom[4] = HALT;
      end
      2: begin
        dut.rom[0]  = e_ldi(3'd1, 8'd5);
        dut.rom[1]  = e_ldi(3'd0, 8'd0);
        dut.rom[2]  = e_beqz(3'd1, 6'd0);
        dut.rom[3]  = e_ldi(3'd2, 8'h22);
        dut.rom[4]  = e_beqz(3'd0, 6'd8);
        dut.rom[5]  = e_ldi(3'd6, 8'hFF);
        dut.rom[6]  = e_ldi(3'd6, 8'hEE);
        dut.rom[8]  = e_ldi(3'd7, 8'd1);
        dut.rom[9]  = e_jmp(8'd12);
        dut.rom[10] = e_ldi(3'd3, 8'h33);
        dut.rom[11] = e_ldi(3'd3, 8'h44);
        dut.rom[12] = HALT;
      end
      default: begin
        dut.rom[0] = e_ldi(3'd1, 8'd1);
        dut.rom[4] = HALT;
        dut.rom[5] = e_ldi(3'd2, 8'd9);
        dut.rom[6] = HALT;
      end
    endcase
  endtask

  task automatic do_reset(input int id);
    @(negedge main_clk);
    restart = 1'b0;
    load_prog(id);
    @(negedge main_clk);
    restart = 1'b1;
  endtask

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (!halted && n < 100) begin
      @(negedge main_clk);
      n++;
    end
    total++;
    if (!halted) begin
      bad++;
      $display("FAIL %s: halt timeout got halted=0 want 1", nm);
    end
  endtask

  task automatic check_prog(input int id, input string nm);
    logic [7:0] act;
    foreach (tbl[i]) begin
      if (tbl[i].prog == id) begin
        case (tbl[i].kind)
          0:       act = dut.r1.registers[tbl[i].idx];
          1:       act = dut.m1.memory[tbl[i].idx];
          2:       act = pc;
          default: act = {7'd0, halted};
        endcase
        check8($sformatf("%s[k%0d i%0d]", nm, tbl[i].kind, tbl[i].idx), act, tbl[i].exp);
      end
    end
  endtask

  task automatic add(input int p, input int k, input int i, input logic [7:0] e);
    chk_t c;
    c.prog = p; c.kind = k; c.idx = i; c.exp = e;
    tbl.push_back(c);
  endtask

  initial begin
    restart = 1'b1;
    controller_enable = 1'b1;
    resume = 1'b0;

    add(0, 0, 1, 8'd5);  add(0, 0, 2, 8'd3);  add(0, 0, 3, 8'd8);
    add(0, 0, 4, 8'd2);  add(0, 0, 5, 8'd1);  add(0, 0, 6, 8'd7);
    add(0, 0, 7, 8'd6);  add(0, 2, 0, 8'd8);  add(0, 3, 0, 8'd1);
    add(1, 0, 1, 8'h04); add(1, 0, 2, 8'hAA); add(1, 0, 5, 8'hAA);
    add(1, 1, 4, 8'hAA); add(1, 1, 0, 8'h00); add(1, 1, 5, 8'h00);
    add(1, 1, 15, 8'h00); add(1, 2, 0, 8'd5);
    add(2, 0, 1, 8'd5);  add(2, 0, 0, 8'd0);  add(2, 0, 2, 8'h22);
    add(2, 0, 6, 8'h00); add(2, 0, 7, 8'd1);  add(2, 0, 3, 8'h00);
    add(2, 2, 0, 8'd13); add(2, 3, 0, 8'd1);

    // power-on reset state
    #3 restart = 1'b0;
    #1;
    check8("rst_pc", pc, 8'h00);
    check8("rst_halted", {7'd0, halted}, 8'h00);
    check8("rst_r0", dut.r1.registers[0], 8'h00);
    check8("rst_m0", dut.m1.memory[0], 8'h00);
    load_prog(0);
    @(negedge main_clk);
    restart = 1'b1;
    cycles(1);
    check8("first_fetch_pc", pc, 8'h01);
    wait_halt("prog0");
    check_prog(0, "arith");

    for (int p = 1; p < 3; p++) begin
      do_reset(p);
      check8($sformatf("reset_clears_halt_p%0d", p), {7'd0, halted}, 8'h00);
      wait_halt($sformatf("prog%0d", p));
      check_prog(p, $sformatf("prog%0d", p));
    end

    // halt/resume: resume high on the HALT-entry edge must be ignored
    do_reset(3);
    cycles(5);
    resume = 1'b1;
    cycles(1);
    resume = 1'b0;
    check8("halt_enter", {7'd0, halted}, 8'h01);
    check8("halt_pc", pc, 8'h05);
    cycles(3);
    check8("halt_hold", {7'd0, halted}, 8'h01);
    check8("halt_hold_pc", pc, 8'h05);
    check8("halt_r1", dut.r1.registers[1], 8'd1);
    check8("halt_r2_untouched", dut.r1.registers[2], 8'h00);
    resume = 1'b1;
    cycles(1);
    resume = 1'b0;
    check8("resume_clear", {7'd0, halted}, 8'h00);
    wait_halt("resume_run");
    check8("resume_r2", dut.r1.registers[2], 8'd9);
    check8("resume_pc", pc, 8'd7);

    // freeze mid-program with a writeback still pending
    do_reset(0);
    cycles(3);
    controller_enable = 1'b0;
    cycles(20);
    check8("freeze_pc", pc, 8'h03);
    check8("freeze_r1", dut.r1.registers[1], 8'd5);
    check8("freeze_r2", dut.r1.registers[2], 8'h00);
    check8("freeze_halted", {7'd0, halted}, 8'h00);
    controller_enable = 1'b1;
    wait_halt("freeze_run");
    check_prog(0, "freeze");

    // asynchronous reset between edges after the store landed
    do_reset(1);
    cycles(4);
    check8("pre_areset_m4", dut.m1.memory[4], 8'hAA);
    #2 restart = 1'b0;
    #1;
    check8("areset_pc", pc, 8'h00);
    check8("areset_halted", {7'd0, halted}, 8'h00);
    check8("areset_m4", dut.m1.memory[4], 8'h00);
    check8("areset_r1", dut.r1.registers[1], 8'h00);
    check8("areset_r2", dut.r1.registers[2], 8'h00);
    @(negedge main_clk);
    restart = 1'b1;
    wait_halt("areset_run");
    check_prog(1, "rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
